// File: rtl/subleq_pkg.sv
// rtl/subleq_pkg.sv - shared widths and state encoding for the SUBLEQ core
//
// Contents:
//   WORD_W, ADDR_W : data and address widths (8 bits each)
//   INSTR_LEN      : bytes per instruction (A, B, C)
//   state_e        : instruction sequencing states
package subleq_pkg;

    localparam int WORD_W    = 8;
    localparam int ADDR_W    = 8;
    localparam int INSTR_LEN = 3;

    typedef enum logic [2:0] {
        FETCH_A = 3'd0,
        FETCH_B = 3'd1,
        FETCH_C = 3'd2,
        LOAD_A  = 3'd3,
        LOAD_B  = 3'd4,
        WRITE   = 3'd5,
        HALT    = 3'd6
    } state_e;

endpackage

// File: rtl/subleq_if.sv
// rtl/subleq_if.sv - memory bus between the SUBLEQ core and its 256x8 memory
//
// Signals:
//   mem_addr  : byte address (core -> memory)
//   mem_wdata : write data (core -> memory)
//   mem_we    : write enable, committed on the rising clock edge (core -> memory)
//   mem_rdata : combinational read data for mem_addr (memory -> core)
// Modports: master (core side), slave (memory side)
interface subleq_if;
    import subleq_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );

endinterface

// File: rtl/subleq_alu.sv
// rtl/subleq_alu.sv - combinational subtract, branch test and next-PC for SUBLEQ
//
// Ports:
//   va      : in  value of mem[A]
//   rdata   : in  value of mem[B] (memory read data)
//   pc      : in  address of the current instruction
//   c       : in  signed branch offset
//   d       : out mem[B] - mem[A], wrapping mod 256
//   leq     : out d <= 0 as a signed value
//   next_pc : out pc+3+c when leq, else pc+3 (both mod 256)
module subleq_alu
    import subleq_pkg::*;
(
    input  logic [WORD_W-1:0] va,
    input  logic [WORD_W-1:0] rdata,
    input  logic [ADDR_W-1:0] pc,
    input  logic [WORD_W-1:0] c,
    output logic [WORD_W-1:0] d,
    output logic              leq,
    output logic [ADDR_W-1:0] next_pc
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_LEN);

    logic [ADDR_W-1:0] fall_through;

    assign d            = rdata - va;
    assign leq          = d[WORD_W-1] | (d == '0);
    assign fall_through = pc + STEP;
    // Adding the 8-bit two's complement offset modulo 256 is the signed add.
    assign next_pc      = leq ? (fall_through + c) : fall_through;

endmodule

// File: rtl/subleq_core.sv
// rtl/subleq_core.sv - six-cycle SUBLEQ processor driving a 256x8 unified memory
//
// Ports:
//   clk    : in  rising-edge clock
//   rst_n  : in  asynchronous active-low reset
//   run    : in  0 holds all state and forces mem_we low
//   bus    : subleq_if.master memory bus (mem_addr, mem_wdata, mem_we, mem_rdata)
//   pc     : out address of the instruction in progress
//   halted : out high once a taken branch lands on HALT_ADDR
//   icount : out retired-instruction count, saturating (only with SUBLEQ_ICOUNT_EN)
// Parameters: RESET_PC (PC after reset), HALT_ADDR (taken target that halts)
// Build option: define SUBLEQ_ICOUNT_EN to add the icount port and counter.
module subleq_core
    import subleq_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 8'd1,
    parameter logic [ADDR_W-1:0] HALT_ADDR = 8'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    subleq_if.master          bus,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
`ifdef SUBLEQ_ICOUNT_EN
    ,
    output logic [15:0]       icount
`endif
);

    localparam logic [2:0] ST_FETCH_A = FETCH_A;
    localparam logic [2:0] ST_FETCH_B = FETCH_B;
    localparam logic [2:0] ST_FETCH_C = FETCH_C;
    localparam logic [2:0] ST_LOAD_A  = LOAD_A;
    localparam logic [2:0] ST_LOAD_B  = LOAD_B;
    localparam logic [2:0] ST_WRITE   = WRITE;
    localparam logic [2:0] ST_HALT    = HALT;

    logic [2:0]        state;
    logic [ADDR_W-1:0] a_reg;
    logic [ADDR_W-1:0] b_reg;
    logic [WORD_W-1:0] c_reg;
    logic [WORD_W-1:0] va_reg;
    logic [WORD_W-1:0] d_reg;
    // Branch outcome is captured alongside D so the WRITE cycle depends only
    // on registers, not on memory still presenting mem[B].
    logic              leq_reg;
    logic [ADDR_W-1:0] npc_reg;

    logic [WORD_W-1:0] alu_d;
    logic              alu_leq;
    logic [ADDR_W-1:0] alu_next_pc;

    subleq_alu u_alu (
        .va      (va_reg),
        .rdata   (bus.mem_rdata),
        .pc      (pc),
        .c       (c_reg),
        .d       (alu_d),
        .leq     (alu_leq),
        .next_pc (alu_next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_FETCH_A;
            pc      <= RESET_PC;
            a_reg   <= '0;
            b_reg   <= '0;
            c_reg   <= '0;
            va_reg  <= '0;
            d_reg   <= '0;
            leq_reg <= 1'b0;
            npc_reg <= '0;
        end else if (run) begin
            case (state)
                ST_FETCH_A: begin
                    a_reg <= bus.mem_rdata;
                    state <= ST_FETCH_B;
                end
                ST_FETCH_B: begin
                    b_reg <= bus.mem_rdata;
                    state <= ST_FETCH_C;
                end
                ST_FETCH_C: begin
                    c_reg <= bus.mem_rdata;
                    state <= ST_LOAD_A;
                end
                ST_LOAD_A: begin
                    va_reg <= bus.mem_rdata;
                    state  <= ST_LOAD_B;
                end
                ST_LOAD_B: begin
                    d_reg   <= alu_d;
                    leq_reg <= alu_leq;
                    npc_reg <= alu_next_pc;
                    state   <= ST_WRITE;
                end
                ST_WRITE: begin
                    pc    <= npc_reg;
                    state <= (leq_reg && (npc_reg == HALT_ADDR)) ? ST_HALT : ST_FETCH_A;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_FETCH_A;
                end
            endcase
        end
    end

    always_comb begin
        bus.mem_addr = pc;
        case (state)
            ST_FETCH_A: bus.mem_addr = pc;
            ST_FETCH_B: bus.mem_addr = pc + 8'd1;
            ST_FETCH_C: bus.mem_addr = pc + 8'd2;
            ST_LOAD_A:  bus.mem_addr = a_reg;
            ST_LOAD_B:  bus.mem_addr = b_reg;
            ST_WRITE:   bus.mem_addr = b_reg;
            default:    bus.mem_addr = pc;
        endcase
    end

    // Decoded from registered state and run only; reset clears state
    // asynchronously, which drops an in-flight write immediately.
    assign bus.mem_we    = run && (state == ST_WRITE);
    assign bus.mem_wdata = (state == ST_WRITE) ? d_reg : '0;
    assign halted        = (state == ST_HALT);

`ifdef SUBLEQ_ICOUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icount <= '0;
        end else if (run && (state == ST_WRITE) && (icount != 16'hFFFF)) begin
            icount <= icount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_subleq_core.sv
// tb/tb_subleq_core.sv - directed self-checking bench for subleq_core with a write scoreboard
module tb_subleq_core;
    import subleq_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       run   = 1'b0;
    logic [7:0] pc;
    logic       halted;
`ifdef SUBLEQ_ICOUNT_EN
    logic [15:0] icount;
`endif

    subleq_if bus ();

    subleq_core #(
        .RESET_PC  (8'd1),
        .HALT_ADDR (8'd0)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .bus    (bus),
        .pc     (pc),
        .halted (halted)
`ifdef SUBLEQ_ICOUNT_EN
        ,
        .icount (icount)
`endif
    );

    initial forever #5 clk = ~clk;

    // Memory model: combinational read, synchronous write; clr/ld ports let
    // the bench preload it while the core is held in reset.
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic       clr     = 1'b0;
    logic       ld_we   = 1'b0;
    logic [7:0] ld_addr = 8'd0;
    logic [7:0] ld_data = 8'd0;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
        end else if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    logic [15:0] exp_q [$];
    int          vectors     = 0;
    int          miscompares = 0;

    logic [7:0] div_prog [12] = '{8'd17, 8'd16, 8'd3, 8'd20, 8'd18, 8'hFA,
                                  8'd18, 8'd19, 8'd0, 8'd20, 8'd0,  8'hF3};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One clock; any write presented this cycle is scored against the model.
    task automatic step();
        logic [15:0] e;
        if (bus.mem_we === 1'b1) begin
            e = 'x;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            chk("write_addr_data", {bus.mem_addr, bus.mem_wdata}, e);
        end
        cyc();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        ref_mem[a] = d;
        ld_addr    = a;
        ld_data    = d;
        ld_we      = 1'b1;
        cyc();
        ld_we      = 1'b0;
    endtask

    task automatic begin_test();
        rst_n = 1'b0;
        run   = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    // Instruction-level reference: pushes each expected {B, D} write.
    task automatic model(input int max_n);
        logic [7:0] p, a, b, c, d, np;
        bit         done;
        p    = 8'd1;
        done = 1'b0;
        for (int n = 0; n < max_n && !done; n++) begin
            a  = ref_mem[p];
            b  = ref_mem[p + 8'd1];
            c  = ref_mem[p + 8'd2];
            d  = ref_mem[b] - ref_mem[a];
            ref_mem[b] = d;
            exp_q.push_back({b, d});
            if (d[7] || d == 8'd0) np = p + 8'd3 + c;
            else                   np = p + 8'd3;
            if ((d[7] || d == 8'd0) && np == 8'd0) done = 1'b1;
            p = np;
        end
    endtask

    task automatic run_to_halt(input int bound, output int n);
        n = 0;
        while (halted !== 1'b1 && n < bound) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        @(negedge clk);

        // Reset state
        chk("rst_pc", 16'(pc), 16'h01);
        chk("rst_halted", 16'(halted), 16'h0);
        chk("rst_we", 16'(bus.mem_we), 16'h0);
        chk("rst_wdata", 16'(bus.mem_wdata), 16'h0);
        chk("rst_addr", 16'(bus.mem_addr), 16'h01);

        // Division program
        begin_test();
        for (int i = 0; i < 12; i++) poke(8'(i + 1), div_prog[i]);
        poke(8'd16, 8'd24);
        poke(8'd17, 8'd7);
        poke(8'd20, 8'd1);
        model(50);
        rst_n = 1'b1;
        run_to_halt(200, n);
        chk("div_cycles", 16'(n), 16'd54);
        chk("div_halted", 16'(halted), 16'h1);
        chk("div_pc", 16'(pc), 16'h00);
        chk("div_m19", 16'(mem[19]), 16'h03);
        chk("div_m16", 16'(mem[16]), 16'hFC);
        chk("div_m18", 16'(mem[18]), 16'hFD);
        chk("div_m0", 16'(mem[0]), 16'hFF);
        chk("div_queue", 16'(exp_q.size()), 16'd0);
`ifdef SUBLEQ_ICOUNT_EN
        chk("div_icount", icount, 16'd9);
`endif
        steps(3);
        chk("halt_hold_pc", 16'(pc), 16'h00);
        chk("halt_hold_we", 16'(bus.mem_we), 16'h0);
        chk("halt_hold_addr", 16'(bus.mem_addr), 16'h00);

        // A == B always branches
        begin_test();
        poke(8'd1, 8'd30);
        poke(8'd2, 8'd30);
        poke(8'd3, 8'd5);
        poke(8'd30, 8'h55);
        model(1);
        rst_n = 1'b1;
        steps(6);
        chk("alias_pc", 16'(pc), 16'h09);
        chk("alias_mem", 16'(mem[30]), 16'h00);
        chk("alias_halted", 16'(halted), 16'h0);
        chk("alias_queue", 16'(exp_q.size()), 16'd0);

        // Not taken, then 0x80-1 wraps positive
        begin_test();
        poke(8'd1, 8'd40);
        poke(8'd2, 8'd41);
        poke(8'd3, 8'd7);
        poke(8'd4, 8'd42);
        poke(8'd5, 8'd43);
        poke(8'd6, 8'd9);
        poke(8'd40, 8'd3);
        poke(8'd41, 8'd10);
        poke(8'd42, 8'd1);
        poke(8'd43, 8'h80);
        model(2);
        rst_n = 1'b1;
        steps(6);
        chk("nt_pc", 16'(pc), 16'h04);
        chk("nt_mem", 16'(mem[41]), 16'h07);
        steps(6);
        chk("wrap_pc", 16'(pc), 16'h07);
        chk("wrap_mem", 16'(mem[43]), 16'h7F);
        chk("nt_queue", 16'(exp_q.size()), 16'd0);

        // run=0 for three cycles while in LOAD_B
        begin_test();
        poke(8'd1, 8'd40);
        poke(8'd2, 8'd41);
        poke(8'd3, 8'd7);
        poke(8'd40, 8'd3);
        poke(8'd41, 8'd10);
        model(1);
        rst_n = 1'b1;
        steps(4);
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_we", 16'(bus.mem_we), 16'h0);
            chk("stall_addr", 16'(bus.mem_addr), 16'd41);
            step();
        end
        run = 1'b1;
        chk("resume_we", 16'(bus.mem_we), 16'h0);
        chk("resume_pc", 16'(pc), 16'h01);
        steps(2);
        chk("stall_pc", 16'(pc), 16'h04);
        chk("stall_mem", 16'(mem[41]), 16'h07);
        chk("stall_queue", 16'(exp_q.size()), 16'd0);

        // Reset asserted in the WRITE cycle
        begin_test();
        poke(8'd1, 8'd40);
        poke(8'd2, 8'd41);
        poke(8'd3, 8'd7);
        poke(8'd40, 8'd3);
        poke(8'd41, 8'd10);
        rst_n = 1'b1;
        steps(5);
        chk("wr_we_before", 16'(bus.mem_we), 16'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_we", 16'(bus.mem_we), 16'h0);
        cyc();
        chk("abort_mem", 16'(mem[41]), 16'd10);
        rst_n = 1'b1;
        chk("abort_pc", 16'(pc), 16'h01);
        chk("abort_halted", 16'(halted), 16'h0);
        chk("abort_addr", 16'(bus.mem_addr), 16'h01);
        cyc();
        chk("abort_fetch_b", 16'(bus.mem_addr), 16'h02);

        // Taken branch from 253 with C=0 wraps onto HALT_ADDR
        begin_test();
        poke(8'd1, 8'd100);
        poke(8'd2, 8'd100);
        poke(8'd3, 8'hF9);
        poke(8'd253, 8'd101);
        poke(8'd254, 8'd102);
        poke(8'd255, 8'd0);
        poke(8'd101, 8'd5);
        poke(8'd102, 8'd5);
        model(10);
        rst_n = 1'b1;
        run_to_halt(100, n);
        chk("w253_cycles", 16'(n), 16'd12);
        chk("w253_halted", 16'(halted), 16'h1);
        chk("w253_pc", 16'(pc), 16'h00);
        chk("w253_mem", 16'(mem[102]), 16'h00);
        chk("w253_queue", 16'(exp_q.size()), 16'd0);

        // Instruction at 254: B from 255, C from 0, target wraps to 3
        begin_test();
        poke(8'd1, 8'd100);
        poke(8'd2, 8'd100);
        poke(8'd3, 8'hFA);
        poke(8'd254, 8'd110);
        poke(8'd255, 8'd111);
        poke(8'd0, 8'd2);
        poke(8'd110, 8'd1);
        poke(8'd111, 8'd1);
        model(2);
        rst_n = 1'b1;
        steps(6);
        chk("w254_jump_pc", 16'(pc), 16'd254);
        steps(6);
        chk("w254_pc", 16'(pc), 16'h03);
        chk("w254_halted", 16'(halted), 16'h0);
        chk("w254_mem", 16'(mem[111]), 16'h00);
        chk("w254_queue", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
